// File: rtl/softmax_argmax_if.sv
// Enable/ack handshake and data bundle for softmax_argmax.
// SOFTMAX_ARGMAX_TOP2_EN adds the runner-up outputs secondIndex/secondValue.
interface softmax_argmax_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_NUM  = 10
);
  localparam int IDX_WIDTH = $clog2(INPUT_NUM);

  logic                            enable;
  logic                            mode;
  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs;
  logic [IDX_WIDTH-1:0]            maxIndex;
  logic [DATA_WIDTH-1:0]           maxValue;
  logic                            ackArg;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [IDX_WIDTH-1:0]            secondIndex;
  logic [DATA_WIDTH-1:0]           secondValue;

  modport master (
    output enable, mode, inputs,
    input  maxIndex, maxValue, ackArg, secondIndex, secondValue
  );
  modport slave (
    input  enable, mode, inputs,
    output maxIndex, maxValue, ackArg, secondIndex, secondValue
  );
`else
  modport master (
    output enable, mode, inputs,
    input  maxIndex, maxValue, ackArg
  );
  modport slave (
    input  enable, mode, inputs,
    output maxIndex, maxValue, ackArg
  );
`endif
endinterface

// File: rtl/softmax_argmax.sv
// Argmax/argmin scan over a packed IEEE-754 vector, LANES elements per cycle.
// Define SOFTMAX_ARGMAX_TOP2_EN to also report the runner-up (secondIndex/secondValue).
module softmax_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int INPUT_NUM  = 10,
  parameter int LANES      = 1
) (
  input  logic            clk,
  input  logic            reset,
  softmax_argmax_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(INPUT_NUM);
  localparam int MAN_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;
  localparam int PTR_WIDTH = $clog2(INPUT_NUM + LANES) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef logic [IDX_WIDTH-1:0]  idx_t;

  logic [1:0]           state;
  logic [PTR_WIDTH-1:0] ptr;
  elem_t                vec_q [INPUT_NUM];
  logic                 mode_q;
  idx_t                 best_idx, nxt_best_idx, res_idx;
  elem_t                best_val, nxt_best_val, res_val;
  logic                 res_ack;
  logic                 last_group;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  idx_t                 sec_idx, nxt_sec_idx, res_sec_idx;
  elem_t                sec_val, nxt_sec_val, res_sec_val;
  logic                 sec_vld, nxt_sec_vld;
`endif

  function automatic logic is_nan(input elem_t x);
    return (&x[DATA_WIDTH-2 -: EXP_WIDTH]) && (|x[MAN_WIDTH-1:0]);
  endfunction

  // Unsigned key with the same ordering as the sign-magnitude value; -0 folds onto +0.
  function automatic elem_t order_key(input elem_t x);
    if (x[DATA_WIDTH-1] && (x[DATA_WIDTH-2:0] != '0))
      return {1'b0, ~x[DATA_WIDTH-2:0]};
    return {1'b1, x[DATA_WIDTH-2:0]};
  endfunction

  // True when a strictly outranks b; NaN ranks below every number.
  function automatic logic beats(input elem_t a, input elem_t b, input logic use_min);
    if (is_nan(a)) return 1'b0;
    if (is_nan(b)) return 1'b1;
    return use_min ? (order_key(a) < order_key(b)) : (order_key(a) > order_key(b));
  endfunction

  assign last_group = (int'(ptr) + LANES) >= INPUT_NUM;

  always_comb begin : lane_chain
    int    idx;
    elem_t cand;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    nxt_best_idx = best_idx;
    nxt_best_val = best_val;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    nxt_sec_idx  = sec_idx;
    nxt_sec_val  = sec_val;
    nxt_sec_vld  = sec_vld;
`endif
    idx  = 0;
    cand = '0;
    for (int j = 0; j < LANES; j++) begin
      idx = int'(ptr) + j;
      // Element 0 seeds the best at load, so it is never offered a second time.
      if (idx > 0 && idx < INPUT_NUM) begin
        cand = vec_q[idx_t'(idx)];
        if (beats(cand, nxt_best_val, mode_q)) begin
`ifdef SOFTMAX_ARGMAX_TOP2_EN
          nxt_sec_idx = nxt_best_idx;
          nxt_sec_val = nxt_best_val;
          nxt_sec_vld = 1'b1;
`endif
          nxt_best_idx = idx_t'(idx);
          nxt_best_val = cand;
        end
`ifdef SOFTMAX_ARGMAX_TOP2_EN
        else if (!nxt_sec_vld || beats(cand, nxt_sec_val, mode_q)) begin
          nxt_sec_idx = idx_t'(idx);
          nxt_sec_val = cand;
          nxt_sec_vld = 1'b1;
        end
`endif
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      mode_q   <= 1'b0;
      // NOTE: the capture buffer is a register array, not a RAM, so it takes the async reset too.
      vec_q    <= '{default: '0};
      best_idx <= '0;
      best_val <= '0;
      res_idx  <= '0;
      res_val  <= '0;
      res_ack  <= 1'b0;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      sec_idx     <= '0;
      sec_val     <= '0;
      sec_vld     <= 1'b0;
      res_sec_idx <= '0;
      res_sec_val <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            for (int i = 0; i < INPUT_NUM; i++)
              vec_q[i] <= bus.inputs[DATA_WIDTH*i +: DATA_WIDTH];
            mode_q   <= bus.mode;
            best_idx <= '0;
            best_val <= bus.inputs[DATA_WIDTH-1:0];
`ifdef SOFTMAX_ARGMAX_TOP2_EN
            sec_vld  <= 1'b0;
`endif
            ptr      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else begin
            best_idx <= nxt_best_idx;
            best_val <= nxt_best_val;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
            sec_idx  <= nxt_sec_idx;
            sec_val  <= nxt_sec_val;
            sec_vld  <= nxt_sec_vld;
`endif
            ptr      <= ptr + PTR_WIDTH'(LANES);
            if (last_group) begin
              res_idx <= nxt_best_idx;
              res_val <= nxt_best_val;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
              res_sec_idx <= nxt_sec_idx;
              res_sec_val <= nxt_sec_val;
`endif
              res_ack <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.enable) begin
            res_ack <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.maxIndex = res_idx;
  assign bus.maxValue = res_val;
  assign bus.ackArg   = res_ack;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  assign bus.secondIndex = res_sec_idx;
  assign bus.secondValue = res_sec_val;
`endif
endmodule

// File: tb/tb_softmax_argmax.sv
// Self-checking bench: three softmax_argmax instances (LANES 1, 4, 3) share one stimulus
// and are compared every cycle against an integer-ordering reference model.
`timescale 1ns/1ps
module tb_softmax_argmax;
  localparam int DW   = 32;
  localparam int N    = 10;
  localparam int IW   = 4;
  localparam int NDUT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable;
  logic            mode;
  logic [DW*N-1:0] inputs;

  logic [IW-1:0]   o_idx [NDUT];
  logic [DW-1:0]   o_val [NDUT];
  logic            o_ack [NDUT];
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [IW-1:0]   o_sidx [NDUT];
  logic [DW-1:0]   o_sval [NDUT];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat [NDUT];

  always #5 clk = ~clk;

  softmax_argmax_if #(.DATA_WIDTH(DW), .INPUT_NUM(N)) bus0 ();
  softmax_argmax_if #(.DATA_WIDTH(DW), .INPUT_NUM(N)) bus1 ();
  softmax_argmax_if #(.DATA_WIDTH(DW), .INPUT_NUM(N)) bus2 ();

  assign bus0.enable = enable;  assign bus0.mode = mode;  assign bus0.inputs = inputs;
  assign bus1.enable = enable;  assign bus1.mode = mode;  assign bus1.inputs = inputs;
  assign bus2.enable = enable;  assign bus2.mode = mode;  assign bus2.inputs = inputs;

  softmax_argmax #(.DATA_WIDTH(DW), .EXP_WIDTH(8), .INPUT_NUM(N), .LANES(1))
    dut0 (.clk(clk), .reset(rst), .bus(bus0));
  softmax_argmax #(.DATA_WIDTH(DW), .EXP_WIDTH(8), .INPUT_NUM(N), .LANES(4))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));
  softmax_argmax #(.DATA_WIDTH(DW), .EXP_WIDTH(8), .INPUT_NUM(N), .LANES(3))
    dut2 (.clk(clk), .reset(rst), .bus(bus2));

  assign o_idx[0] = bus0.maxIndex;  assign o_val[0] = bus0.maxValue;  assign o_ack[0] = bus0.ackArg;
  assign o_idx[1] = bus1.maxIndex;  assign o_val[1] = bus1.maxValue;  assign o_ack[1] = bus1.ackArg;
  assign o_idx[2] = bus2.maxIndex;  assign o_val[2] = bus2.maxValue;  assign o_ack[2] = bus2.ackArg;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  assign o_sidx[0] = bus0.secondIndex;  assign o_sval[0] = bus0.secondValue;
  assign o_sidx[1] = bus1.secondIndex;  assign o_sval[1] = bus1.secondValue;
  assign o_sidx[2] = bus2.secondIndex;  assign o_sval[2] = bus2.secondValue;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int groups(input int k);
    int l;
    l = (k == 0) ? 1 : (k == 1) ? 4 : 3;
    return (N + l - 1) / l;
  endfunction

  function automatic logic [31:0] elem(input logic [DW*N-1:0] v, input int i);
    return v[32*i +: 32];
  endfunction

  function automatic bit isnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // IEEE-754 values order exactly like their sign-magnitude integers (and -0 == +0).
  function automatic longint sval(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  // Lowest index holding the extreme non-NaN value, excluding 'skip';
  // with no number left, the lowest remaining index.
  function automatic int pick(input logic [DW*N-1:0] v, input bit mn, input int skip);
    int     best;
    longint ext;
    best = -1;
    ext  = 0;
    for (int i = 0; i < N; i++)
      if (i != skip && !isnan(elem(v, i)))
        if (best < 0 || (mn ? sval(elem(v, i)) < ext : sval(elem(v, i)) > ext)) begin
          best = i;
          ext  = sval(elem(v, i));
        end
    if (best < 0)
      for (int i = N - 1; i >= 0; i--)
        if (i != skip) best = i;
    return best;
  endfunction

  int              m_cnt  [NDUT] = '{default: -1};
  bit              m_ack  [NDUT] = '{default: 1'b0};
  int              m_idx  [NDUT] = '{default: 0};
  logic [31:0]     m_val  [NDUT] = '{default: '0};
  int              m_sidx [NDUT] = '{default: 0};
  logic [31:0]     m_sval [NDUT] = '{default: '0};
  logic [DW*N-1:0] m_vec  [NDUT];
  bit              m_mode [NDUT];

  // Expected outputs after each edge: load, G scan edges, then hold until enable drops.
  always @(posedge clk or posedge rst) begin : model_upd
    int bi, si;
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_cnt[k] <= -1;  m_ack[k] <= 1'b0;
        m_idx[k] <= 0;   m_val[k] <= '0;
        m_sidx[k] <= 0;  m_sval[k] <= '0;
      end else if (m_ack[k]) begin
        if (!enable) m_ack[k] <= 1'b0;
      end else if (m_cnt[k] >= 0) begin
        if (!enable) m_cnt[k] <= -1;
        else if (m_cnt[k] + 1 == groups(k)) begin
          bi = pick(m_vec[k], m_mode[k], -1);
          si = pick(m_vec[k], m_mode[k], bi);
          m_ack[k]  <= 1'b1;
          m_cnt[k]  <= -1;
          m_idx[k]  <= bi;
          m_val[k]  <= elem(m_vec[k], bi);
          m_sidx[k] <= si;
          m_sval[k] <= elem(m_vec[k], si);
        end else m_cnt[k] <= m_cnt[k] + 1;
      end else if (enable) begin
        m_vec[k]  <= inputs;
        m_mode[k] <= mode;
        m_cnt[k]  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("ack[dut%0d]", k), 64'(o_ack[k]), 64'(m_ack[k]));
      check($sformatf("maxIndex[dut%0d]", k), 64'(o_idx[k]), 64'(m_idx[k]));
      check($sformatf("maxValue[dut%0d]", k), 64'(o_val[k]), 64'(m_val[k]));
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      check($sformatf("secondIndex[dut%0d]", k), 64'(o_sidx[k]), 64'(m_sidx[k]));
      check($sformatf("secondValue[dut%0d]", k), 64'(o_sval[k]), 64'(m_sval[k]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_elem(input int flavour);
    logic s;
    s = 1'($urandom_range(0, 1));
    case (flavour)
      0:       return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1:       return {s, 31'h7F800000};
      2:       return {s, 31'h0};
      3:       return {s, 31'h3F800000};
      4:       return {s, 8'h00, 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    int              style;
    style = $urandom_range(0, 9);
    for (int i = 0; i < N; i++)
      v[32*i +: 32] = (style == 0) ? rand_elem(0) :
                      (style == 1) ? rand_elem($urandom_range(0, 3)) :
                                     rand_elem($urandom_range(0, 9));
    return v;
  endfunction

  // Raise enable with v/md, scramble inputs and mode during the scan, optionally drop
  // enable after abort_at cycles; lat[k] records the cycle each ack is first seen.
  task automatic run_op(input logic [DW*N-1:0] v, input bit md, input int abort_at);
    int cyc;
    bit all_done;
    for (int k = 0; k < NDUT; k++) lat[k] = -1;
    inputs = v;
    mode   = md;
    enable = 1'b1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < NDUT; k++)
        if (o_ack[k] && lat[k] < 0) lat[k] = cyc;
      if (cyc == 2) begin
        inputs = rand_vec();
        mode   = ~md;
      end
      if (cyc == abort_at) enable = 1'b0;
      all_done = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0);
    end while (!all_done && cyc < 30 && !(abort_at > 0 && cyc >= abort_at));
    if (abort_at == 0 && !all_done)
      check("ack_timeout", 64'(all_done), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    enable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [DW*N-1:0] tv, v;

  initial begin
    enable = 1'b0;
    mode   = 1'b0;
    inputs = '0;
    tv = {32'h3EA56042, 32'h3F8E147B, 32'hBCA3D70A, 32'h40466666, 32'h3E99999A,
          32'hBF666666, 32'h3FA66666, 32'h3F99999A, 32'hBE4CCCCD, 32'h3E4CCCCD};

    // Pin the model with hand-derived answers.
    check("model_argmax", 64'(pick(tv, 1'b0, -1)), 64'd6);
    check("model_argmin", 64'(pick(tv, 1'b1, -1)), 64'd4);
    check("model_second", 64'(pick(tv, 1'b0, 6)), 64'd3);
    v = {N{32'h3F800000}};
    check("model_ties", 64'(pick(v, 1'b0, -1)), 64'd0);
    v = {N{32'h7FC00000}};
    check("model_all_nan", 64'(pick(v, 1'b0, -1)), 64'd0);
    check("model_all_nan_second", 64'(pick(v, 1'b0, 0)), 64'd1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ack", 64'(o_ack[0]), 64'd0);
    check("reset_idx", 64'(o_idx[1]), 64'd0);
    check("reset_val", 64'(o_val[2]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Argmax on the reference vector, inputs scrambled mid-scan.
    run_op(tv, 1'b0, 0);
    check("lat_l1", 64'(lat[0]), 64'd11);
    check("lat_l4", 64'(lat[1]), 64'd4);
    check("lat_l3", 64'(lat[2]), 64'd5);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("argmax_idx[dut%0d]", k), 64'(o_idx[k]), 64'd6);
      check($sformatf("argmax_val[dut%0d]", k), 64'(o_val[k]), 64'h40466666);
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      check($sformatf("argmax_second_idx[dut%0d]", k), 64'(o_sidx[k]), 64'd3);
      check($sformatf("argmax_second_val[dut%0d]", k), 64'(o_sval[k]), 64'h3FA66666);
`endif
    end
    repeat (3) @(negedge clk);
    check("ack_held", 64'(o_ack[0]), 64'd1);
    idle_cycles(1);
    check("ack_falls", 64'(o_ack[0]), 64'd0);

    run_op(tv, 1'b1, 0);
    check("argmin_idx", 64'(o_idx[0]), 64'd4);
    check("argmin_val", 64'(o_val[1]), 64'hBF666666);
    idle_cycles(2);

    run_op({N{32'h3F800000}}, 1'b0, 0);
    check("ties_idx", 64'(o_idx[2]), 64'd0);
    idle_cycles(2);

    v = {N{32'hBF800000}};
    v[31:0]  = 32'hC0000000;
    v[127:96] = 32'h7FC00000;
    run_op(v, 1'b0, 0);
    check("nan_skip_idx", 64'(o_idx[0]), 64'd1);
    idle_cycles(2);

    run_op({5{32'h00000000, 32'h80000000}}, 1'b0, 0);
    check("zeros_idx", 64'(o_idx[0]), 64'd0);
    check("zeros_val", 64'(o_val[0]), 64'h80000000);
    idle_cycles(2);

    // Abort mid-scan: the LANES=1 instance keeps its previous result.
    run_op(tv, 1'b0, 5);
    repeat (2) @(negedge clk);
    check("abort_ack", 64'(o_ack[0]), 64'd0);
    check("abort_idx_kept", 64'(o_idx[0]), 64'd0);
    check("abort_val_kept", 64'(o_val[0]), 64'h80000000);
    v = tv;
    v[31:0] = 32'h3F30A3D7;
    run_op(v, 1'b0, 0);
    check("rerun_lat", 64'(lat[0]), 64'd11);
    check("rerun_idx", 64'(o_idx[0]), 64'd6);
    idle_cycles(2);

    // Asynchronous reset in the middle of a scan.
    inputs = tv;
    mode   = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", 64'(o_ack[1]), 64'd0);
    check("async_rst_idx", 64'(o_idx[0]), 64'd0);
    check("async_rst_val", 64'(o_val[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(o_ack[0]), 64'd0);
    run_op(tv, 1'b0, 0);
    check("post_rst_lat", 64'(lat[0]), 64'd11);
    idle_cycles(1);

    // Randomized operations, some aborted, checked every cycle by the compare process.
    for (int t = 0; t < 200; t++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      run_op(rand_vec(), 1'($urandom_range(0, 1)), ab);
      if (ab == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      idle_cycles($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/softmax_argmax.md
# softmax_argmax

Parametrised classifier stage that follows the softmax layer in the CNN output path. It scans a packed vector of IEEE-754 values and returns the index and value of the largest element, or the smallest in argmin mode. It processes LANES elements per cycle and uses the same enable/ack handshake as the softmax stage. The input vector is captured at start, so upstream may change `inputs` while a scan is running.

## Interface
- DATA_WIDTH, 32: element width, 1 sign + EXP_WIDTH exponent + mantissa bits.
- EXP_WIDTH, 8: exponent field width. Use 5 with DATA_WIDTH=16 for half precision.
- INPUT_NUM, 10: number of elements, ≥2.
- LANES, 1: elements compared per cycle, 1..INPUT_NUM. It need not divide INPUT_NUM.
- IDX_WIDTH (localparam): $clog2(INPUT_NUM).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level start/hold. Low returns the block to idle.
- mode  in  1  0 = argmax, 1 = argmin. Sampled at load.
- inputs  in  DATA_WIDTH*INPUT_NUM  element i at [DATA_WIDTH*i +: DATA_WIDTH].
- maxIndex  out  IDX_WIDTH  index of the selected element.
- maxValue  out  DATA_WIDTH  raw bits of the selected element.
- ackArg  out  1  result valid. Held high while enable stays high.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - When enable=1 at a clock edge: register `inputs` and `mode`, set best = element 0, ptr = 0, and go to SCAN.
- SCAN: each cycle, compare the best so far against elements ptr..ptr+LANES-1, then add LANES to ptr.
  - Lanes with index ≥ INPUT_NUM are ignored.
  - Element 0 compared against itself is harmless.
  - After the group containing INPUT_NUM-1: load maxIndex/maxValue, set ackArg=1, go to DONE.
- DONE: hold. When enable=0: go to IDLE and clear ackArg.
- Abort: enable=0 in SCAN returns to IDLE on the next edge. ackArg stays 0 and maxIndex/maxValue keep the previous result.
- Restart: a new operation requires enable low for at least one edge between operations.
- Comparison (no FP arithmetic, sign-magnitude compare only):
  - Positive beats negative.
  - Between two positives, the larger magnitude wins. Between two negatives, the smaller magnitude wins.
  - +0 and -0 are equal.
  - Infinities order normally.
- NaN (exponent all ones, mantissa ≠ 0): never selected in either mode. If every element is NaN, return index 0 and its bits.
- Ties: strict comparison, so the lowest index wins. Within one cycle's lanes, the lower index has priority.
- argmin uses the mirrored ordering with the same NaN and tie rules.

## Timing
- Reset values: state IDLE, maxIndex=0, maxValue=0, ackArg=0, ptr=0, captured vector 0.
- Reset is asynchronous. Asserting it mid-scan forces IDLE immediately. The block restarts only after reset is released and enable is seen high at an edge.
- Let G = ceil(INPUT_NUM/LANES).
  - Edge 1 with enable high: load.
  - Edges 2..G+1: scan.
  - ackArg and the results are valid after edge G+1, so latency is G+1 cycles.
  - Example: N=10, L=1 gives 11 cycles. N=10, L=4 gives 4 cycles.
- Outputs are registered. They change only on the SCAN→DONE edge and on reset.
- ackArg falls on the first edge after enable is seen low.

## Configuration
- SOFTMAX_ARGMAX_TOP2_EN:
  - Defined: adds output ports secondIndex [IDX_WIDTH] and secondValue [DATA_WIDTH].
    - They report the runner-up under the same ordering, NaN and tie rules, and are updated alongside maxIndex. Reset value 0.
    - If only one non-NaN element exists, the runner-up is the lowest-index remaining element.
  - Undefined: the ports and the runner-up logic are absent. Everything else is identical.

## Test plan
- Argmax, N=10, L=1, mode=0. Elements 0..9 = 0.2, -0.2, 1.2, 1.3, -0.9, 0.3, 3.1, -0.02, 1.11, 0.323. Expect maxIndex=6, maxValue=0x40466666, ackArg high 11 cycles after enable. With TOP2 defined: secondIndex=3, secondValue=0x3FA66666.
- Same vector, mode=1. Expect maxIndex=4, maxValue=0xBF666666.
- Same vector, L=4. Expect the same result as the argmax case with ackArg after 4 cycles. Change `inputs` during the scan; the result must not change.
- Ties and edge values:
  - All elements 0x3F800000: expect maxIndex=0.
  - Element 3 = 0x7FC00000 (NaN), all others negative: the NaN is not selected.
  - Elements 0x80000000 and 0x00000000 only: expect maxIndex=0.
- Abort: drop enable at scan cycle 5. ackArg must stay 0 and the outputs must keep the prior result. Re-raise enable with 0.69 at index 0: full 11-cycle scan gives index 6.
- Assert reset mid-scan. Outputs and ackArg must go to 0 immediately, and the block must stay in IDLE until enable is seen high after reset release.
